alu_spi_master: RTL and testbench

// - Processor-side SPI master for the serial ALU: accepts an operation + two operands, serialises an AluPacket
//   to the ALU slave, waits for the result, deserialises REGISTER_SIZE bits and hands it back to the core.
// - Sits directly upstream of the ALU slave on the shared Spi bus; one bit per i_clock cycle, both ends on i_clock.

---
 rtl/alu_spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_alu_spi_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_spi_master.sv
// Processor-side SPI master for the serial ALU: ships {op_2, op_1, op_code} LSB first, then collects the result.
// Optional abort-on-silence watchdog in START/WAIT is enabled by defining ALU_MASTER_TIMEOUT_EN.

package Isa;
  localparam int REGISTER_SIZE = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } Operation;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op_2;
    logic [REGISTER_SIZE-1:0] op_1;
    Operation                 op_code;
  } AluPacket;
endpackage

interface Spi #(
  parameter int NssWidth = 1
) ();
  logic [NssWidth-1:0] nss;
  logic                mosi;
  logic                miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

module alu_spi_master
  import Isa::*;
#(
  parameter int NssPosition   = 0,
  parameter int TimeoutCycles = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  Operation                 i_op,
  input  logic [REGISTER_SIZE-1:0] i_op_1,
  input  logic [REGISTER_SIZE-1:0] i_op_2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_error,
  Spi.MasterSpi                    spi
);

  localparam int PW   = $bits(AluPacket);
  localparam int RS   = REGISTER_SIZE;
  localparam int CntW = $clog2(PW);
  localparam int RsW  = $clog2(RS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TX,
    S_WAIT,
    S_RX,
    S_DONE,
    S_ABORT
  } state_t;

  state_t          state, next_state;
  logic [CntW-1:0] cnt;
  AluPacket        packet;
  logic [PW-1:0]   packet_bits;
  logic [RS-1:0]   result_q;
  logic            busy_q;
  logic            nss_bit, mosi_bit, done_bit;
  logic            cnt_tx_last, cnt_rx_last;

  assign packet_bits = packet;
  assign cnt_tx_last = (cnt == CntW'(PW - 1));
  assign cnt_rx_last = (cnt == CntW'(RS - 1));

`ifdef ALU_MASTER_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);

  logic [WaitW-1:0] wait_cnt;
  logic             timed_out;
  logic             error_bit;

  assign timed_out = (wait_cnt == WaitW'(TimeoutCycles - 1));

  // Counts consecutive cycles spent stalled in START or WAIT; cleared on any state change.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= '0;
    end else if ((state == S_START || state == S_WAIT) && next_state == state) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign o_error = error_bit;
`else
  assign o_error = 1'b0;
`endif

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
    next_state = state;
    nss_bit    = 1'b1;
    mosi_bit   = 1'b0;
    done_bit   = 1'b0;
`ifdef ALU_MASTER_TIMEOUT_EN
    error_bit  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (i_start) next_state = S_START;
      end
      S_START: begin
        nss_bit  = 1'b0;
        mosi_bit = 1'b1;
        if (!spi.miso) next_state = S_TX;
`ifdef ALU_MASTER_TIMEOUT_EN
        else if (timed_out) next_state = S_ABORT;
`endif
      end
      S_TX: begin
        nss_bit  = 1'b0;
        mosi_bit = packet_bits[cnt];
        if (cnt_tx_last) next_state = S_WAIT;
      end
      S_WAIT: begin
        nss_bit = 1'b0;
        if (spi.miso) next_state = S_RX;
`ifdef ALU_MASTER_TIMEOUT_EN
        else if (timed_out) next_state = S_ABORT;
`endif
      end
      S_RX: begin
        nss_bit = 1'b0;
        if (cnt_rx_last) next_state = S_DONE;
      end
      S_DONE: begin
        done_bit   = 1'b1;
        next_state = S_IDLE;
      end
`ifdef ALU_MASTER_TIMEOUT_EN
      S_ABORT: begin
        error_bit  = 1'b1;
        next_state = S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shared bit counter, result shift-in and busy flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt      <= '0;
      packet   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_start) begin
            packet <= '{op_2: i_op_2, op_1: i_op_1, op_code: i_op};
            busy_q <= 1'b1;
          end
        end
        S_TX: begin
          cnt <= cnt_tx_last ? '0 : cnt + 1'b1;
        end
        S_RX: begin
          result_q[cnt[RsW-1:0]] <= spi.miso;
          cnt                    <= cnt_rx_last ? '0 : cnt + 1'b1;
        end
        S_DONE, S_ABORT: begin
          busy_q <= 1'b0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign spi.nss[NssPosition] = nss_bit;
  assign spi.mosi             = mosi_bit;
  assign o_busy               = busy_q;
  assign o_done               = done_bit;
  assign o_result             = result_q;

endmodule

// File: tb/tb_alu_spi_master.sv
// Scoreboard bench for alu_spi_master with a behavioural ALU slave on the SPI bus.
// Define ALU_MASTER_TIMEOUT_EN to also exercise the abort path.
module tb_alu_spi_master;
  import Isa::*;

  localparam int PW      = $bits(AluPacket);
  localparam int RS      = REGISTER_SIZE;
  localparam int LATENCY = PW + RS + 3;

  typedef struct {
    logic [RS-1:0] res;
    logic [PW-1:0] pkt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  Operation      i_op;
  logic [RS-1:0] i_op_1, i_op_2;
  logic          o_busy, o_done, o_error;
  logic [RS-1:0] o_result;

  Spi #(.NssWidth(1)) spi_bus ();

  alu_spi_master #(
    .NssPosition  (0),
    .TimeoutCycles(64)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_op_1  (i_op_1),
    .i_op_2  (i_op_2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_result(o_result),
    .o_error (o_error),
    .spi     (spi_bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t sb[$];
  int   acc_cyc = 0;
  int   last_done_cyc = 0;
  int   gap = 0;
  int   done_count = 0;
  int   error_count = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural ALU slave: start bit, PW packet bits, one compute cycle, ready flag, RS result bits.
  int            s_state = 0;
  int            s_cnt = 0;
  logic [PW-1:0] s_pkt, cap_pkt;
  logic [RS-1:0] s_res;
  bit            slave_en = 1'b1;

  function automatic logic [RS-1:0] alu(input logic [PW-1:0] p);
    logic [RS-1:0] x, y;
    x = p[RS+1:2];
    y = p[2*RS+1:RS+2];
    case (p[1:0])
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state      <= 0;
      s_cnt        <= 0;
      spi_bus.miso <= 1'b0;
    end else if (!slave_en) begin
      s_state      <= 0;
      spi_bus.miso <= 1'b1;
    end else begin
      case (s_state)
        0: begin
          spi_bus.miso <= 1'b0;
          if (!spi_bus.nss[0] && spi_bus.mosi) begin
            s_state <= 1;
            s_cnt   <= 0;
          end
        end
        1: begin
          s_pkt[s_cnt] <= spi_bus.mosi;
          if (s_cnt == PW - 1) s_state <= 2;
          else s_cnt <= s_cnt + 1;
        end
        2: begin
          cap_pkt      <= s_pkt;
          s_res        <= alu(s_pkt);
          spi_bus.miso <= 1'b1;
          s_cnt        <= 0;
          s_state      <= 3;
        end
        3: begin
          spi_bus.miso <= s_res[s_cnt];
          if (s_cnt == RS - 1) s_state <= 4;
          else s_cnt <= s_cnt + 1;
        end
        default: begin
          spi_bus.miso <= 1'b0;
          s_state      <= 0;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every o_done, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_busy && !prev_busy) begin
        acc_cyc = cyc;
        gap     = cyc - last_done_cyc;
      end
      if (o_done || o_error) check("done_error_exclusive", {31'd0, o_done & o_error}, 32'd0);
      if (o_error) error_count++;
      if (o_done) begin
        done_count++;
        last_done_cyc = cyc;
        check("done_with_pending", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("result", {24'd0, o_result}, {24'd0, e.res});
          check("mosi_packet", {14'd0, cap_pkt}, {14'd0, e.pkt});
          check("latency", cyc - acc_cyc, LATENCY);
        end
      end
    end
    prev_busy = o_busy;
  end

  task automatic issue(input Operation op, input logic [RS-1:0] x, input logic [RS-1:0] y,
                       input logic [RS-1:0] res, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("issue_ready", {31'd0, ok}, 32'd1);
    i_op    = op;
    i_op_1  = x;
    i_op_2  = y;
    i_start = 1'b1;
    if (push) begin
      e.res = res;
      e.pkt = {y, x, op};
      sb.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int d0;
    rst     = 1'b1;
    i_start = 1'b0;
    i_op    = OP_ADD;
    i_op_1  = '0;
    i_op_2  = '0;
    repeat (3) @(negedge clk);
    check("rst_nss", {31'd0, spi_bus.nss[0]}, 32'd1);
    check("rst_mosi", {31'd0, spi_bus.mosi}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    check("rst_result", {24'd0, o_result}, 32'd0);
    rst = 1'b0;

    issue(OP_ADD, 8'd3, 8'd5, 8'd8, 1'b1);
    wait_idle();
    issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b1);
    wait_idle();
    issue(OP_OR, 8'hF0, 8'h0F, 8'hFF, 1'b1);
    wait_idle();
    issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1);
    wait_idle();
    issue(OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("result_hold", {24'd0, o_result}, 32'h0F);

    // Back-to-back: second request accepted on the first edge of the IDLE cycle after DONE.
    issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1);
    issue(OP_AND, 8'hAA, 8'h0F, 8'h0A, 1'b1);
    wait_idle();
    check("b2b_gap", gap, 32'd2);

    // A start pulse during TX must be dropped.
    d0 = done_count;
    issue(OP_ADD, 8'h21, 8'h12, 8'h33, 1'b1);
    repeat (8) @(negedge clk);
    check("busy_in_tx", {31'd0, o_busy}, 32'd1);
    i_op    = OP_OR;
    i_op_1  = 8'hFF;
    i_op_2  = 8'hFF;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("single_done", done_count - d0, 32'd1);

    // Reset in the middle of TX drops the transfer.
    d0 = done_count;
    issue(OP_ADD, 8'h11, 8'h22, 8'h33, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_nss", {31'd0, spi_bus.nss[0]}, 32'd1);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_mosi", {31'd0, spi_bus.mosi}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_result", {24'd0, o_result}, 32'd0);
    check("midrst_no_done", done_count - d0, 32'd0);
    issue(OP_ADD, 8'd1, 8'd1, 8'd2, 1'b1);
    wait_idle();

`ifdef ALU_MASTER_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      slave_en = 1'b0;
      repeat (2) @(negedge clk);
      d0 = done_count;
      issue(OP_ADD, 8'd4, 8'd4, 8'd0, 1'b0);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (o_error) begin
          seen = 1'b1;
          check("abort_latency", cyc - acc_cyc, 32'd64);
          check("abort_nss", {31'd0, spi_bus.nss[0]}, 32'd1);
          break;
        end
      end
      check("abort_seen", {31'd0, seen}, 32'd1);
      repeat (3) @(negedge clk);
      check("abort_no_done", done_count - d0, 32'd0);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_result_kept", {24'd0, o_result}, 32'd2);
      slave_en = 1'b1;
    end
`else
    check("error_never", error_count, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
